// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: shared types and constants for the MEM-stage load/store unit.
package mem_access_unit_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int FUNCT3_HI  = 14;
  localparam int FUNCT3_LO  = 12;

  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mas_state_e;

  // Stores only know B/H/W; loads add the unsigned byte/half variants.
  function automatic logic funct3_legal(input logic [2:0] funct3, input logic is_store);
    logic ok;
    if (is_store) begin
      ok = (funct3 == MEM_B) || (funct3 == MEM_H) || (funct3 == MEM_W);
    end else begin
      ok = (funct3 == MEM_B) || (funct3 == MEM_H) || (funct3 == MEM_W) ||
           (funct3 == MEM_BU) || (funct3 == MEM_HU);
    end
    return ok;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extender.sv
// mem_access_unit_load_extender: picks the addressed lane out of a read word and
// sign/zero-extends it according to the load funct3. Purely combinational.
module mem_access_unit_load_extender
  import mem_access_unit_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic [1:0]            offset_i,
  input  logic [2:0]            funct3_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select followed by extension; halfword lane ignores offset bit 0.
  always_comb begin
    case (offset_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (funct3_i)
      MEM_B:   data_o = {{24{byte_sel[7]}}, byte_sel};
      MEM_BU:  data_o = {24'h0, byte_sel};
      MEM_H:   data_o = {{16{half_sel[15]}}, half_sel};
      MEM_HU:  data_o = {16'h0, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit. Latches one EX/MEM access, runs a
// req/ack handshake with a variable-latency data memory while stalling the
// pipeline, and returns lane-extracted, extended load data.
// Optional feature: define MEM_MISALIGN_CHECK_EN to reject misaligned half/word
// accesses with a misalign_o pulse instead of silently aligning them.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read_i,
  input  logic                  mem_write_i,
  input  logic [DATA_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic [DATA_WIDTH-1:0] instruction_i,
  output logic                  dmem_req_o,
  output logic                  dmem_we_o,
  output logic [ADDR_WIDTH-1:0] dmem_addr_o,
  output logic [DATA_WIDTH-1:0] dmem_wdata_o,
  output logic [3:0]            dmem_be_o,
  input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
  input  logic                  dmem_ack_i,
  output logic [DATA_WIDTH-1:0] load_data_o,
  output logic                  stall_o,
`ifdef MEM_MISALIGN_CHECK_EN
  output logic                  misalign_o,
`endif
  output logic                  access_fault_o
);

  logic                  access;
  logic                  is_store;
  logic                  legal;
  logic                  misaligned;
  logic                  start;
  logic [2:0]            funct3;
  logic [3:0]            be_new;
  logic [DATA_WIDTH-1:0] wdata_new;
  logic [DATA_WIDTH-1:0] ext_data;
  logic                  unused_instr_bits;

  mas_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]            be_q, be_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [1:0]            offset_q, offset_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] load_data_q, load_data_d;
  logic                  fault_q, fault_d;

  // A simultaneous read and write is treated as a store.
  assign access            = mem_read_i | mem_write_i;
  assign is_store          = mem_write_i;
  assign funct3            = instruction_i[FUNCT3_HI:FUNCT3_LO];
  assign legal             = funct3_legal(funct3, is_store);
  assign unused_instr_bits = ^{instruction_i[DATA_WIDTH-1:FUNCT3_HI+1], instruction_i[FUNCT3_LO-1:0]};
  assign start             = (state_q == IDLE) & access & legal & ~misaligned;
  assign fault_d           = (state_q == IDLE) & access & ~legal;

`ifdef MEM_MISALIGN_CHECK_EN
  logic misalign_q;

  // Size-vs-address alignment test for halfword and word accesses.
  always_comb begin
    misaligned = 1'b0;
    case (funct3)
      MEM_H, MEM_HU: misaligned = addr_i[0];
      MEM_W:         misaligned = |addr_i[1:0];
      default:       misaligned = 1'b0;
    endcase
  end

  // One-cycle misalignment pulse; no request is issued for such an access.
  always_ff @(posedge clk) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= (state_q == IDLE) & access & legal & misaligned;
  end

  assign misalign_o = misalign_q;
`else
  assign misaligned = 1'b0;
`endif

  // Store lane placement: enables from the low address bits, data replicated on every lane.
  always_comb begin
    be_new    = 4'b1111;
    wdata_new = '0;
    if (is_store) begin
      case (funct3)
        MEM_B: begin
          be_new    = 4'b0001 << addr_i[1:0];
          wdata_new = {4{wr_data_i[7:0]}};
        end
        MEM_H: begin
          be_new    = 4'b0011 << {addr_i[1], 1'b0};
          wdata_new = {2{wr_data_i[15:0]}};
        end
        default: begin
          be_new    = 4'b1111;
          wdata_new = wr_data_i;
        end
      endcase
    end
  end

  mem_access_unit_load_extender u_load_extender (
    .rdata_i  (dmem_rdata_i),
    .offset_i (offset_q),
    .funct3_i (funct3_q),
    .data_o   (ext_data)
  );

  // Next-state, latch enables and stall; stall is combinational so the access cycle itself freezes.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    funct3_d    = funct3_q;
    offset_d    = offset_q;
    we_d        = we_q;
    load_data_d = load_data_q;
    stall_o     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = BUSY;
          addr_d   = {addr_i[ADDR_WIDTH-1:2], 2'b00};
          wdata_d  = wdata_new;
          be_d     = be_new;
          funct3_d = funct3;
          offset_d = addr_i[1:0];
          we_d     = is_store;
          stall_o  = 1'b1;
        end
      end
      BUSY: begin
        stall_o = 1'b1;
        if (dmem_ack_i) begin
          if (!we_q) load_data_d = ext_data;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Latched bus fields, load result and fault pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      funct3_q    <= '0;
      offset_q    <= '0;
      we_q        <= 1'b0;
      load_data_q <= '0;
      fault_q     <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      funct3_q    <= funct3_d;
      offset_q    <= offset_d;
      we_q        <= we_d;
      load_data_q <= load_data_d;
      fault_q     <= fault_d;
    end
  end

  assign dmem_req_o     = (state_q == BUSY);
  assign dmem_we_o      = we_q;
  assign dmem_addr_o    = addr_q;
  assign dmem_wdata_o   = wdata_q;
  assign dmem_be_o      = be_q;
  assign load_data_o    = load_data_q;
  assign access_fault_o = fault_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed table, hand-written corner sequences and a
// randomized run against a byte-addressed reference memory.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [31:0] addr, wr_data, instr;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] load_data;
  logic        stall, fault;
`ifdef MEM_MISALIGN_CHECK_EN
  logic        misalign;
`endif

  mem_access_unit #(.ADDR_WIDTH(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_read_i     (mem_read),
    .mem_write_i    (mem_write),
    .addr_i         (addr),
    .wr_data_i      (wr_data),
    .instruction_i  (instr),
    .dmem_req_o     (dmem_req),
    .dmem_we_o      (dmem_we),
    .dmem_addr_o    (dmem_addr),
    .dmem_wdata_o   (dmem_wdata),
    .dmem_be_o      (dmem_be),
    .dmem_rdata_i   (dmem_rdata),
    .dmem_ack_i     (dmem_ack),
    .load_data_o    (load_data),
    .stall_o        (stall),
`ifdef MEM_MISALIGN_CHECK_EN
    .misalign_o     (misalign),
`endif
    .access_fault_o (fault)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Memory device behind the bus (word array) and reference byte memory.
  logic [31:0] smem [0:255];
  logic [7:0]  rmem [0:1023];

  // Request-rise monitor for the back-to-back sequence.
  int   cyc = 0, rises = 0, last_rise = 0, prev_rise = 0;
  logic req_d = 1'b0;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    req_d <= dmem_req;
    if (dmem_req && !req_d) begin
      rises     <= rises + 1;
      prev_rise <= last_rise;
      last_rise <= cyc;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Results of the last run_access call.
  int          r_stall;
  logic        r_req, r_fault, r_mis, r_unstable, r_we, r_done_stall, r_done_req;
  logic [31:0] r_addr, r_wdata, r_ld;
  logic [3:0]  r_be;

  // Presents one access as EX/MEM would (held through DONE), plays the memory
  // with an ack after ack_dly BUSY cycles, and records what the bus showed.
  task automatic run_access(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [31:0] d, input logic [2:0] f3, input int ack_dly);
    int   n;
    logic done;
    logic [7:0] idx;
    mem_read = rd; mem_write = wr; addr = a; wr_data = d;
    instr = {17'h0, f3, 12'h003};
    r_stall = 0; r_req = 1'b0; r_fault = 1'b0; r_mis = 1'b0; r_unstable = 1'b0;
    r_ld = '0; r_done_stall = 1'b0; r_done_req = 1'b0;
    #1;
    if (stall) r_stall++;
    @(posedge clk); #1;
    if (!dmem_req) begin
      r_fault = fault;
`ifdef MEM_MISALIGN_CHECK_EN
      r_mis = misalign;
`endif
      mem_read = 1'b0; mem_write = 1'b0;
      return;
    end
    r_req = 1'b1; r_addr = dmem_addr; r_be = dmem_be; r_wdata = dmem_wdata; r_we = dmem_we;
    n = 0; done = 1'b0;
    while (!done && n <= 40) begin
      if (stall) r_stall++;
      if (!dmem_req || dmem_addr !== r_addr || dmem_be !== r_be ||
          dmem_wdata !== r_wdata || dmem_we !== r_we) r_unstable = 1'b1;
      if (n == ack_dly) begin
        idx = dmem_addr[9:2];
        dmem_rdata = smem[idx];
        if (dmem_we)
          for (int b = 0; b < 4; b++)
            if (dmem_be[b]) smem[idx][8*b +: 8] = dmem_wdata[8*b +: 8];
        dmem_ack = 1'b1;
        done = 1'b1;
      end else begin
        dmem_rdata = $urandom;
      end
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      n++;
    end
    if (!done) chk("ack_timeout", 32'd1, 32'd0);
    r_ld = load_data; r_done_stall = stall; r_done_req = dmem_req;
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  // Reference model: byte memory with size-aligned effective addresses.
  function automatic int ref_size(input logic [2:0] f3);
    return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic int ref_base(input logic [31:0] a, input logic [2:0] f3);
    int n = ref_size(f3);
    return int'(a) - (int'(a) % n);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] f3);
    int n = ref_size(f3);
    int base = ref_base(a, f3);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = rmem[base + i];
    if (!f3[2] && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
    if (!f3[2] && n == 2 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  function automatic logic [3:0] ref_be(input logic [31:0] a, input logic [2:0] f3, input logic st);
    int n = ref_size(f3);
    int base = ref_base(a, f3);
    logic [3:0] be = '0;
    if (!st) return 4'hF;
    for (int i = 0; i < n; i++) be[(base + i) % 4] = 1'b1;
    return be;
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    int n = ref_size(f3);
    int base = ref_base(a, f3);
    for (int i = 0; i < n; i++) rmem[base + i] = d[8*i +: 8];
  endtask

  typedef struct {
    logic        rd, wr;
    logic [31:0] a, d;
    logic [2:0]  f3;
    logic        pre_en;
    logic [31:0] pre_val;
    int          ack_dly;
    logic        exp_fault;
    int          exp_stall;
    logic [3:0]  exp_be;
    logic [31:0] exp_val;   // store: bus wdata, load: load_data_o in DONE
  } vec_t;

  localparam int NV = 17;
  vec_t tbl [NV];

  initial begin
    vec_t        v;
    logic [31:0] ld_before, a, d, exp_ld;
    logic [2:0]  f3;
    logic        st, legal, mis;
    int          ad, r0, sel;
    string       p;

    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; addr = '0; wr_data = '0; instr = '0;
    dmem_rdata = '0; dmem_ack = 1'b0;
    for (int w = 0; w < 256; w++) smem[w] = '0;

    //          rd    wr    a             d             f3      pre   pre_val       ad  flt   st  be     val
    tbl[0]  = '{1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 3'b010, 1'b0, 32'h0,        1, 1'b0, 3, 4'hF, 32'hDEADBEEF};
    tbl[1]  = '{1'b1, 1'b0, 32'h203, 32'h0,        3'b000, 1'b1, 32'h80FF1234, 0, 1'b0, 2, 4'hF, 32'hFFFFFF80};
    tbl[2]  = '{1'b1, 1'b0, 32'h203, 32'h0,        3'b100, 1'b0, 32'h0,        0, 1'b0, 2, 4'hF, 32'h00000080};
    tbl[3]  = '{1'b0, 1'b1, 32'h042, 32'h0000ABCD, 3'b001, 1'b0, 32'h0,        0, 1'b0, 2, 4'hC, 32'hABCDABCD};
    tbl[4]  = '{1'b1, 1'b0, 32'h042, 32'h0,        3'b001, 1'b0, 32'h0,        0, 1'b0, 2, 4'hF, 32'hFFFFABCD};
    tbl[5]  = '{1'b1, 1'b0, 32'h042, 32'h0,        3'b101, 1'b0, 32'h0,        2, 1'b0, 4, 4'hF, 32'h0000ABCD};
    tbl[6]  = '{1'b0, 1'b1, 32'h301, 32'h000000A5, 3'b000, 1'b1, 32'h11223344, 0, 1'b0, 2, 4'h2, 32'hA5A5A5A5};
    tbl[7]  = '{1'b1, 1'b0, 32'h301, 32'h0,        3'b000, 1'b0, 32'h0,        0, 1'b0, 2, 4'hF, 32'hFFFFFFA5};
    tbl[8]  = '{1'b1, 1'b0, 32'h300, 32'h0,        3'b101, 1'b0, 32'h0,        1, 1'b0, 3, 4'hF, 32'h0000A544};
    tbl[9]  = '{1'b1, 1'b0, 32'h300, 32'h0,        3'b010, 1'b0, 32'h0,        3, 1'b0, 5, 4'hF, 32'h1122A544};
    tbl[10] = '{1'b1, 1'b0, 32'h100, 32'h0,        3'b000, 1'b0, 32'h0,        0, 1'b0, 2, 4'hF, 32'hFFFFFFEF};
    tbl[11] = '{1'b1, 1'b0, 32'h102, 32'h0,        3'b001, 1'b0, 32'h0,        0, 1'b0, 2, 4'hF, 32'hFFFFDEAD};
    tbl[12] = '{1'b1, 1'b0, 32'h000, 32'h0,        3'b011, 1'b0, 32'h0,        0, 1'b1, 0, 4'h0, 32'h0};
    tbl[13] = '{1'b0, 1'b1, 32'h000, 32'h0,        3'b100, 1'b0, 32'h0,        0, 1'b1, 0, 4'h0, 32'h0};
    tbl[14] = '{1'b1, 1'b1, 32'h304, 32'h55AA55AA, 3'b010, 1'b0, 32'h0,        0, 1'b0, 2, 4'hF, 32'h55AA55AA};
    tbl[15] = '{1'b1, 1'b0, 32'h304, 32'h0,        3'b010, 1'b0, 32'h0,        0, 1'b0, 2, 4'hF, 32'h55AA55AA};
    tbl[16] = '{1'b1, 1'b0, 32'h302, 32'h0,        3'b100, 1'b0, 32'h0,        0, 1'b0, 2, 4'hF, 32'h00000022};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req",   dmem_req,   32'd0);
    chk("rst_we",    dmem_we,    32'd0);
    chk("rst_addr",  dmem_addr,  32'd0);
    chk("rst_wdata", dmem_wdata, 32'd0);
    chk("rst_be",    dmem_be,    32'd0);
    chk("rst_load",  load_data,  32'd0);
    chk("rst_fault", fault,      32'd0);
    chk("rst_stall", stall,      32'd0);
`ifdef MEM_MISALIGN_CHECK_EN
    chk("rst_misalign", misalign, 32'd0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    // Ack while idle must be ignored.
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    #1;
    chk("idle_ack_stall", stall, 32'd0);
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    chk("idle_ack_req",  dmem_req,  32'd0);
    chk("idle_ack_load", load_data, 32'd0);
    @(posedge clk); #1;
    chk("idle_ack_req2", dmem_req,  32'd0);

    // Directed table.
    for (int i = 0; i < NV; i++) begin
      v = tbl[i];
      p = $sformatf("tbl%0d", i);
      if (v.pre_en) smem[v.a[9:2]] = v.pre_val;
      run_access(v.rd, v.wr, v.a, v.d, v.f3, v.ack_dly);
      chk({p, "_stall"}, r_stall, v.exp_stall);
      chk({p, "_fault"}, r_fault, v.exp_fault);
      chk({p, "_req"},   r_req,   !v.exp_fault);
      if (!v.exp_fault) begin
        chk({p, "_addr"},   r_addr, v.a & 32'hFFFF_FFFC);
        chk({p, "_be"},     r_be,   v.exp_be);
        chk({p, "_we"},     r_we,   v.wr);
        if (v.wr) chk({p, "_wdata"}, r_wdata, v.exp_val);
        else      chk({p, "_load"},  r_ld,    v.exp_val);
        chk({p, "_stable"},    r_unstable,   32'd0);
        chk({p, "_donestall"}, r_done_stall, 32'd0);
        chk({p, "_donereq"},   r_done_req,   32'd0);
      end
    end

    // Fault is a single-cycle pulse.
    run_access(1'b1, 1'b0, 32'h10, 32'h0, 3'b111, 0);
    chk("fault_pulse", r_fault, 32'd1);
    @(posedge clk); #1;
    chk("fault_clear", fault, 32'd0);

    // Back-to-back LW, LW with immediate ack.
    smem[8'h80] = 32'h80FF1234;
    smem[8'hC1] = 32'h55AA55AA;
    r0 = rises;
    run_access(1'b1, 1'b0, 32'h200, 32'h0, 3'b010, 0);
    chk("b2b_ld0", r_ld, 32'h80FF1234);
    run_access(1'b1, 1'b0, 32'h304, 32'h0, 3'b010, 0);
    chk("b2b_ld1",    r_ld,    32'h55AA55AA);
    chk("b2b_stall1", r_stall, 32'd2);
    chk("b2b_rises",  rises - r0,            32'd2);
    chk("b2b_gap",    last_rise - prev_rise, 32'd3);

    // LW at a misaligned address.
    run_access(1'b1, 1'b0, 32'h101, 32'h0, 3'b010, 0);
`ifdef MEM_MISALIGN_CHECK_EN
    chk("mis_pulse", r_mis,   32'd1);
    chk("mis_req",   r_req,   32'd0);
    chk("mis_stall", r_stall, 32'd0);
    chk("mis_fault", r_fault, 32'd0);
    @(posedge clk); #1;
    chk("mis_clear", misalign, 32'd0);
`else
    chk("mis_req",  r_req,  32'd1);
    chk("mis_addr", r_addr, 32'h100);
    chk("mis_load", r_ld,   32'hDEADBEEF);
`endif

    // Reset in BUSY, ack arriving one cycle late.
    mem_write = 1'b1; addr = 32'h100; wr_data = 32'h12345678; instr = {17'h0, 3'b010, 12'h023};
    @(posedge clk); #1;
    chk("rstmid_busy_req", dmem_req, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; mem_write = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D;
    #1;
    chk("rstmid_req",   dmem_req,  32'd0);
    chk("rstmid_stall", stall,     32'd0);
    chk("rstmid_addr",  dmem_addr, 32'd0);
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    chk("rstmid_req2",  dmem_req,  32'd0);
    chk("rstmid_stall2", stall,    32'd0);
    chk("rstmid_load",  load_data, 32'd0);

    // Randomized accesses against the byte-level reference.
    for (int w = 0; w < 256; w++) begin
      d = $urandom;
      smem[w] = d;
      for (int b = 0; b < 4; b++) rmem[4*w + b] = d[8*b +: 8];
    end
    for (int k = 0; k < 200; k++) begin
      p   = $sformatf("rnd%0d", k);
      st  = 1'($urandom_range(0, 1));
      a   = 32'($urandom_range(0, 1023));
      d   = $urandom;
      ad  = $urandom_range(0, 3);
      sel = $urandom_range(0, 11);
      if (st) begin
        f3 = (sel == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      end else begin
        case (sel)
          0:  f3 = 3'b011;
          1:  f3 = 3'b110;
          2:  f3 = 3'b111;
          3, 4:  f3 = 3'b100;
          5, 6:  f3 = 3'b101;
          default: f3 = 3'($urandom_range(0, 2));
        endcase
      end
      legal = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
      mis = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
      mis = (ref_base(a, f3) != int'(a));
`endif
      exp_ld = ref_load(a, f3);
      run_access(!st, st, a, d, f3, ad);
      if (!legal) begin
        chk({p, "_fault"}, r_fault, 32'd1);
        chk({p, "_req"},   r_req,   32'd0);
        chk({p, "_stall"}, r_stall, 32'd0);
      end else if (mis) begin
        chk({p, "_mis"},   r_mis,   32'd1);
        chk({p, "_req"},   r_req,   32'd0);
        chk({p, "_stall"}, r_stall, 32'd0);
      end else begin
        chk({p, "_req"},   r_req,   32'd1);
        chk({p, "_stall"}, r_stall, 32'(2 + ad));
        chk({p, "_addr"},  r_addr,  a & 32'hFFFF_FFFC);
        chk({p, "_be"},    r_be,    ref_be(a, f3, st));
        chk({p, "_we"},    r_we,    st);
        if (st) ref_store(a, d, f3);
        else    chk({p, "_load"}, r_ld, exp_ld);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
